// File: rtl/sdram_arbiter.sv
// sdram_arbiter: four-requester SDRAM access arbiter with ageing, DMA masking and a start-of-access watchdog
module sdram_arbiter #(
  parameter int AGE_MAX  = 8,
  parameter int WDOG_MAX = 15
) (
  input  logic       clk_sys,
  input  logic       nRESET,
  input  logic [3:0] req_sig,
  input  logic       dma_mode,
  input  logic       sdram_ready,
  output logic       SDRAM_RD_PULSE,
  output logic       SDRAM_WR_PULSE,
  output logic       SDRAM_RD_TYPE,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic [3:0] pending,
  output logic [3:0] overflow,
  output logic       wdog_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic [3:0] prev_q, pending_q, pending_d, grant_q, grant_d, ovf_q, ovf_d;
  logic [3:0] wdog_q, wdog_d;
  logic [3:0] age_q [4];
  logic [3:0] age_d [4];
  logic       wderr_q, wderr_d, rdtype_q, rdtype_d;
  logic [3:0] edge_s, cand, aged, pool, win, accept;
  logic       fin;
  always_comb begin
    edge_s = req_sig & ~prev_q;
    cand   = pending_q & (dma_mode ? 4'b0110 : 4'b1111);
    aged   = '0;
    for (int i = 0; i < 4; i++) aged[i] = cand[i] && age_q[i] == 4'(AGE_MAX);
    pool = |aged ? aged : cand;
    // base order CROM > SROM > CD_WR > M68K
    win  = (state_q == IDLE && sdram_ready) ?
           (pool[1] ? 4'b0010 : pool[2] ? 4'b0100 : pool[0] ? 4'b0001 : pool[3] ? 4'b1000 : 4'b0000) : 4'b0000;
    fin  = sdram_ready && (state_q == WAIT_HIGH || (state_q == WAIT_LOW && wdog_q == 4'(WDOG_MAX)));
    done = fin ? grant_q : 4'b0000;
    // the owner finishing this cycle may re-request; the one being selected may not
    accept    = edge_s & ~(pending_q | (fin ? 4'b0000 : grant_q) | win);
    pending_d = (pending_q & ~win) | accept;
    ovf_d     = ovf_q | (edge_s & ~accept);
    for (int i = 0; i < 4; i++)
      age_d[i] = (win[i] || !pending_q[i]) ? 4'd0 :
                 (cand[i] && |win && age_q[i] != 4'(AGE_MAX)) ? age_q[i] + 4'd1 : age_q[i];
    state_d  = state_q;
    grant_d  = grant_q;
    wdog_d   = wdog_q;
    wderr_d  = wderr_q;
    rdtype_d = rdtype_q;
    unique case (state_q)
      IDLE: if (|win) begin
        state_d  = ISSUE;
        grant_d  = win;
        rdtype_d = win[0] ? rdtype_q : win[1];
      end
      ISSUE: begin
        state_d = WAIT_LOW;
        wdog_d  = 4'd0;
      end
      WAIT_LOW: if (!sdram_ready) state_d = WAIT_HIGH;
        else if (fin) begin
          state_d = IDLE;
          grant_d = 4'd0;
          wderr_d = 1'b1;
        end else wdog_d = wdog_q + 4'd1;
      WAIT_HIGH: if (fin) begin
        state_d = IDLE;
        grant_d = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      prev_q    <= 4'b1111;
      pending_q <= '0;
      grant_q   <= '0;
      ovf_q     <= '0;
      wdog_q    <= '0;
      wderr_q   <= 1'b0;
      rdtype_q  <= 1'b0;
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= req_sig;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      ovf_q     <= ovf_d;
      wdog_q    <= wdog_d;
      wderr_q   <= wderr_d;
      rdtype_q  <= rdtype_d;
      for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
    end
  end
  assign SDRAM_RD_PULSE = state_q == ISSUE && !grant_q[0];
  assign SDRAM_WR_PULSE = state_q == ISSUE && grant_q[0];
  assign SDRAM_RD_TYPE  = rdtype_q;
  assign grant          = grant_q;
  assign pending        = pending_q;
  assign overflow       = ovf_q;
  assign wdog_err       = wderr_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed-vector bench for sdram_arbiter with hand-computed expectations
module tb_sdram_arbiter;
  logic       clk_sys = 1'b0;
  logic       nRESET = 1'b0;
  logic [3:0] req_sig = 4'b0000;
  logic       dma_mode = 1'b0;
  logic       sdram_ready = 1'b1;
  logic       rd_pulse, wr_pulse, rd_type, wdog_err;
  logic [3:0] grant, done, pending, overflow;
  int n_cmp = 0;
  int n_err = 0;

  sdram_arbiter dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .req_sig(req_sig), .dma_mode(dma_mode),
    .sdram_ready(sdram_ready), .SDRAM_RD_PULSE(rd_pulse), .SDRAM_WR_PULSE(wr_pulse),
    .SDRAM_RD_TYPE(rd_type), .grant(grant), .done(done), .pending(pending),
    .overflow(overflow), .wdog_err(wdog_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // called in ISSUE: ready falls, rises two cycles later; req_done is driven on the done cycle
  task automatic finish_access(input logic [3:0] exp_done, input logic [3:0] req_done);
    sdram_ready = 1'b0;
    tick;
    tick;
    sdram_ready = 1'b1;
    req_sig = req_done;
    #1;
    chk("done", done, exp_done);
    tick;
    chk("grant_clr", grant, 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_grant", grant, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_wdog", wdog_err, 0);
    chk("rst_rdtype", rd_type, 0);
    chk("rst_pulses", {rd_pulse, wr_pulse}, 0);
    chk("rst_done", done, 0);
    nRESET = 1'b1;
    tick;
    // single CROM
    req_sig = 4'b0010;
    tick;
    chk("crom_pend", pending, 4'b0010);
    chk("crom_grant0", grant, 0);
    tick;
    chk("crom_rd", rd_pulse, 1);
    chk("crom_wr", wr_pulse, 0);
    chk("crom_type", rd_type, 1);
    chk("crom_grant", grant, 4'b0010);
    chk("crom_pend0", pending, 0);
    finish_access(4'b0010, 4'b0000);
    // simultaneous edges on CD_WR, SROM, M68K
    req_sig = 4'b1101;
    tick;
    chk("sim_pend0", pending, 4'b1101);
    tick;
    chk("sim_g_srom", grant, 4'b0100);
    chk("sim_pend1", pending, 4'b1001);
    chk("sim_rd1", rd_pulse, 1);
    finish_access(4'b0100, 4'b1101);
    tick;
    chk("sim_g_cdwr", grant, 4'b0001);
    chk("sim_wr", {rd_pulse, wr_pulse}, 2'b01);
    chk("sim_pend2", pending, 4'b1000);
    chk("sim_type", rd_type, 0);
    finish_access(4'b0001, 4'b1101);
    tick;
    chk("sim_g_m68k", grant, 4'b1000);
    chk("sim_pend3", pending, 0);
    chk("sim_rd3", rd_pulse, 1);
    finish_access(4'b1000, 4'b0000);
    // starvation: CROM re-requests on each done cycle, M68K waits
    req_sig = 4'b1010;
    tick;
    chk("stv_pend", pending, 4'b1010);
    for (int k = 1; k <= 9; k++) begin
      tick;
      chk($sformatf("stv_grant%0d", k), grant, k == 9 ? 4'b1000 : 4'b0010);
      req_sig = 4'b1000;
      finish_access(k == 9 ? 4'b1000 : 4'b0010, k < 9 ? 4'b1010 : 4'b0000);
    end
    tick;
    chk("stv_crom_last", grant, 4'b0010);
    finish_access(4'b0010, 4'b0000);
    chk("stv_no_ovf", overflow, 0);
    // DMA mask
    dma_mode = 1'b1;
    req_sig = 4'b1100;
    tick;
    chk("dma_pend", pending, 4'b1100);
    tick;
    chk("dma_g_srom", grant, 4'b0100);
    chk("dma_pend1", pending, 4'b1000);
    finish_access(4'b0100, 4'b1100);
    tick;
    chk("dma_hold_grant", grant, 0);
    chk("dma_hold_pend", pending, 4'b1000);
    chk("dma_hold_rd", rd_pulse, 0);
    dma_mode = 1'b0;
    tick;
    chk("dma_g_m68k", grant, 4'b1000);
    chk("dma_pend2", pending, 0);
    finish_access(4'b1000, 4'b0000);
    // overflow then watchdog
    sdram_ready = 1'b0;
    req_sig = 4'b0100;
    tick;
    chk("ovf_pend", pending, 4'b0100);
    req_sig = 4'b0000;
    tick;
    req_sig = 4'b0100;
    tick;
    chk("ovf_flag", overflow, 4'b0100);
    chk("ovf_pend2", pending, 4'b0100);
    sdram_ready = 1'b1;
    tick;
    chk("wd_grant", grant, 4'b0100);
    chk("wd_rd", rd_pulse, 1);
    repeat (15) tick;
    chk("wd_early_done", done, 0);
    chk("wd_early_err", wdog_err, 0);
    tick;
    chk("wd_done", done, 4'b0100);
    chk("wd_err_pre", wdog_err, 0);
    tick;
    chk("wd_err", wdog_err, 1);
    chk("wd_grant0", grant, 0);
    chk("wd_done0", done, 0);
    chk("wd_ovf_sticky", overflow, 4'b0100);
    // reset in WAIT_HIGH
    req_sig = 4'b0000;
    tick;
    req_sig = 4'b0010;
    tick;
    tick;
    chk("rwh_grant", grant, 4'b0010);
    sdram_ready = 1'b0;
    tick;
    tick;
    chk("rwh_grant_wh", grant, 4'b0010);
    nRESET = 1'b0;
    tick;
    sdram_ready = 1'b1;
    #1;
    chk("rwh_grant0", grant, 0);
    chk("rwh_done0", done, 0);
    chk("rwh_flags", {overflow, wdog_err, rd_type}, 0);
    chk("rwh_pend0", pending, 0);
    nRESET = 1'b1;
    tick;
    tick;
    chk("held_pend", pending, 0);
    chk("held_grant", grant, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter AGE_MAX, default 8, is the number of lost arbitrations after which a pending requester is forced to top priority (legal range 2..15).
REQ-002 Parameter WDOG_MAX, default 15, is the cycle limit for sdram_ready to fall after an issue pulse (legal range 2..15).
REQ-003 clk_sys  in  1  system clock; every register changes only on its rising edge.
REQ-004 nRESET  in  1  reset; synchronous and active-low.
REQ-005 req_sig  in  4  request levels, bit0=CD_WR, bit1=CROM, bit2=SROM, bit3=M68K; a 0->1 edge is one request.
REQ-006 dma_mode  in  1  when 1, M68K and CD_WR are masked out of arbitration but stay pending.
REQ-007 sdram_ready  in  1  SDRAM controller idle flag; falls while an access runs and rises at completion.
REQ-008 SDRAM_RD_PULSE  out  1  one-cycle read start strobe.
REQ-009 SDRAM_WR_PULSE  out  1  one-cycle write start strobe.
REQ-010 SDRAM_RD_TYPE  out  1  read type, 1=burst (CROM), 0=single; holds its value between accesses.
REQ-011 grant  out  4  one-hot owner of the current access; 0 when no access is running.
REQ-012 done  out  4  one-cycle completion strobe for the owner.
REQ-013 pending  out  4  latched requests not yet granted.
REQ-014 overflow  out  4  sticky flag: a request was lost because that requester was already pending or granted.
REQ-015 wdog_err  out  1  sticky flag: the watchdog expired.

Function
REQ-016 Edge detect: a request registers when the previous-cycle req_sig bit is 0 and the current bit is 1; the previous-value register resets to all 1s.
REQ-017 A detected edge sets the pending bit; if that bit is already pending or granted, the edge is dropped and the overflow bit is set.
REQ-018 State machine states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-019 IDLE: when sdram_ready=1 and at least one unmasked pending bit exists, the arbiter selects a winner, loads grant, clears that pending bit, and moves to ISSUE on the next cycle.
REQ-020 Base priority is CROM > SROM > CD_WR > M68K.
REQ-021 An unmasked requester whose age counter equals AGE_MAX beats base priority; if several are aged, base order breaks the tie.
REQ-022 Age counters, 4 bits each: in every IDLE selection, each unmasked pending requester that loses increments its counter, saturating at AGE_MAX.
REQ-023 A requester's age counter clears when it is granted or when its pending bit is clear.
REQ-024 ISSUE lasts exactly one cycle.
REQ-025 In ISSUE, SDRAM_WR_PULSE=1 if the grant is CD_WR; otherwise SDRAM_RD_PULSE=1.
REQ-026 In ISSUE, SDRAM_RD_TYPE is set to 1 for a CROM grant and 0 for SROM or M68K; it is unchanged for a CD_WR grant.
REQ-027 From ISSUE the machine goes to WAIT_LOW.
REQ-028 WAIT_LOW: when sdram_ready=0, go to WAIT_HIGH.
REQ-029 WAIT_LOW watchdog: the counter starts at 0 on entry; if it reaches WDOG_MAX while sdram_ready is still 1, set wdog_err, pulse done for the owner, clear grant, and go to IDLE.
REQ-030 WAIT_HIGH: when sdram_ready=1, pulse done for the owner, clear grant, and go to IDLE.
REQ-031 Throughput: the earliest next issue is 2 cycles after a done pulse (IDLE selection cycle, then ISSUE).
REQ-032 Simultaneous events: an edge for the owner on the same cycle as its done pulse is accepted as a new pending request with no overflow.
REQ-033 Simultaneous events: an edge for the requester being selected in IDLE on that same cycle sets overflow.
REQ-034 dma_mode changing while an access runs has no effect on that access; it applies from the next IDLE selection.
REQ-035 The two pulse outputs are never high on the same cycle.
REQ-036 grant is never non-zero outside ISSUE, WAIT_LOW and WAIT_HIGH.

Reset
REQ-037 While nRESET=0 on a clock edge: state=IDLE; grant, done, pending, overflow, wdog_err, both pulses, SDRAM_RD_TYPE, age counters and watchdog all become 0; the edge-detect registers become 1111.
REQ-038 Reset asserted mid-access aborts the access with no done pulse; the SDRAM controller's own reset handles its side.
REQ-039 Requests held high through reset release produce no request until they fall and rise again.

Verification
REQ-040 Single CROM: req_sig[1] 0->1 with ready=1 -> RD_PULSE and RD_TYPE=1 two cycles later; hold ready low 5 cycles, then high -> done=0010 on the rising cycle, grant=0000 after.
REQ-041 Simultaneous: edges on bits 0, 2 and 3 in one cycle -> grants issued in order SROM, CD_WR (WR_PULSE), M68K; pending goes 1101 -> 1001 -> 1000 -> 0000.
REQ-042 Starvation: keep M68K pending while CROM re-requests every access, AGE_MAX=8 -> M68K is granted on the 9th selection.
REQ-043 DMA mask: dma_mode=1 with M68K and SROM pending -> only SROM is issued and M68K stays pending; drop dma_mode -> M68K issues.
REQ-044 Overflow and watchdog: second edge on bit 2 while SROM is pending -> overflow=0100; keep ready high after the pulse -> wdog_err=1 and done=0100 after 15 cycles.
REQ-045 Reset mid-WAIT_HIGH -> all outputs 0 on the next cycle and no done pulse.
